// File: rtl/pcm_pkg.sv
// pcm_pkg: constants and FSM encoding shared by the PCM link
// transmit serializer and microphone receiver.
package pcm_pkg;

  localparam int PCM_CLK_DIV  = 2;
  localparam int PCM_SAMPLE_W = 16;
  localparam int PCM_FRAME_W  = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pcm_state_e;

  // Counter width that stays legal when the range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// bclk_gen: divides clk into the serial bit clock and emits one-clk
// strobes on the cycle bclk is about to fall (fe) or rise (re).
module bclk_gen
  import pcm_pkg::*;
#(
  parameter int CLK_DIV = PCM_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bclk,
  output logic fe,
  output logic re
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] TOP = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = en && (div_cnt == TOP);
  assign fe   = tick & bclk;
  assign re   = tick & ~bclk;

  // Disabled means parked low with the phase reset, so a restart
  // always waits a full half-period before the first rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pcm_tx_serializer.sv
// pcm_tx_serializer: one-entry hold buffer feeding a left-justified,
// MSB-first frame shifter with bclk/ws generation.
module pcm_tx_serializer
  import pcm_pkg::*;
#(
  parameter int CLK_DIV  = PCM_CLK_DIV,
  parameter int SAMPLE_W = PCM_SAMPLE_W,
  parameter int FRAME_W  = PCM_FRAME_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_clk,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                bclk,
  output logic                ws,
  output logic                sdata,
  output logic                underrun,
  output logic                busy
);

  localparam int BW = cnt_w(FRAME_W);
  localparam logic [BW-1:0] LAST = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] HALF = BW'(FRAME_W / 2);

  pcm_state_e state, state_d;

  logic [SAMPLE_W-1:0] hold, hold_d;
  logic [SAMPLE_W-1:0] shreg, shreg_d;
  logic [SAMPLE_W-1:0] shifted;
  logic                hold_full, hold_full_d;
  logic [BW-1:0]       bit_cnt, bit_cnt_d, nxt;
  logic                sdata_d, ws_d, underrun_d;
  logic                load, xfer, run;
  logic                fe, re_unused;

  assign run  = (state == ST_RUN);
  assign busy = run;
  assign xfer = s_valid & s_ready;

  bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk (
    .clk  (clk),
    .reset(reset),
    .en   (run),
    .bclk (bclk),
    .fe   (fe),
    .re   (re_unused)
  );

  assign nxt     = bit_cnt + 1'b1;
  assign shifted = shreg << nxt;

  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    sdata_d    = sdata;
    ws_d       = ws;
    underrun_d = 1'b0;
    load       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        sdata_d   = 1'b0;
        ws_d      = 1'b0;
        bit_cnt_d = '0;
        if (en_clk && hold_full) begin
          state_d = ST_RUN;
          load    = 1'b1;
          shreg_d = hold;
          sdata_d = hold[SAMPLE_W-1];
        end
      end
      ST_RUN: begin
        if (fe && bit_cnt != LAST) begin
          bit_cnt_d = nxt;
          // Bits past the sample fall out of the shifter as zeros.
          sdata_d   = shifted[SAMPLE_W-1];
          ws_d      = (nxt >= HALF);
        end else if (fe) begin
          bit_cnt_d = '0;
          ws_d      = 1'b0;
          unique case (1'b1)
            !en_clk: begin
              state_d = ST_IDLE;
              sdata_d = 1'b0;
            end
            en_clk && hold_full: begin
              load    = 1'b1;
              shreg_d = hold;
              sdata_d = hold[SAMPLE_W-1];
            end
            en_clk && !hold_full: begin
              shreg_d    = '0;
              sdata_d    = 1'b0;
              underrun_d = 1'b1;
            end
            default: begin
              state_d = state;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A load takes the old held word; a same-cycle transfer refills it.
  always_comb begin
    hold_d      = xfer ? s_data : hold;
    hold_full_d = (hold_full & ~load) | xfer;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      s_ready   <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      sdata     <= 1'b0;
      ws        <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      s_ready   <= ~hold_full_d;
      shreg     <= shreg_d;
      bit_cnt   <= bit_cnt_d;
      sdata     <= sdata_d;
      ws        <= ws_d;
      underrun  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pcm_tx_serializer.sv
// tb_pcm_tx_serializer: scoreboard bench; a bclk-rise monitor pops
// expected (sdata, ws) bits queued when each sample is accepted.
module tb_pcm_tx_serializer;

  localparam int SW = 16;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en_clk = 1'b0;
  logic          s_valid = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic          s_ready, bclk, ws, sdata;
  logic          underrun, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic b;
    logic w;
    logic first;
  } exp_t;

  exp_t        q[$];
  int unsigned starts[$];
  int unsigned cyc = 0;
  int          rises = 0;
  int          ur_cnt = 0;
  logic        bclk_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pcm_tx_serializer #(
    .CLK_DIV (2),
    .SAMPLE_W(SW),
    .FRAME_W (FW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en_clk  (en_clk),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .bclk    (bclk),
    .ws      (ws),
    .sdata   (sdata),
    .underrun(underrun),
    .busy    (busy)
  );

  function automatic void push_frame(input logic [SW-1:0] d);
    exp_t e;
    for (int i = 0; i < FW; i++) begin
      e.b     = (i < SW) ? d[SW-1-i] : 1'b0;
      e.w     = (i >= FW / 2);
      e.first = (i == 0);
      q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (underrun === 1'b1) ur_cnt++;
    if (bclk === 1'b1 && bclk_prev === 1'b0) begin
      rises++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL stray_bclk cyc=%0d sdata=%b ws=%b, expected no rise",
                 cyc, sdata, ws);
      end else begin
        e = q.pop_front();
        if (e.first) starts.push_back(cyc);
        if (sdata !== e.b || ws !== e.w) begin
          errors++;
          $display("FAIL serial_bit cyc=%0d got sdata=%b ws=%b expected sdata=%b ws=%b",
                   cyc, sdata, ws, e.b, e.w);
        end
      end
    end
    bclk_prev = bclk;
  end

  task automatic send(input logic [SW-1:0] d);
    int n = 0;
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout data=%h s_ready=%b expected 1", d, s_ready);
    end else begin
      push_frame(d);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    en_clk = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bclk, ws, sdata, s_ready, underrun, busy} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_values got %b expected 000100",
               {bclk, ws, sdata, s_ready, underrun, busy});
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (rises != 0 || busy !== 1'b0 || bclk !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_quiet rises=%0d busy=%b bclk=%b s_ready=%b expected 0 0 0 1",
               rises, busy, bclk, s_ready);
    end
  endtask

  task automatic test_single_frame();
    en_clk = 1'b1;
    send(16'hA5C3);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_latency s_ready=%b busy=%b expected 0 0", s_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sdata !== 1'b1 || ws !== 1'b0 || bclk !== 1'b0) begin
      errors++;
      $display("FAIL run_entry busy=%b sdata=%b ws=%b bclk=%b expected 1 1 0 0",
               busy, sdata, ws, bclk);
    end
    @(negedge clk);
    checks++;
    if (bclk !== 1'b0) begin
      errors++;
      $display("FAIL early_rise bclk=%b expected 0", bclk);
    end
    @(negedge clk);
    checks++;
    if (bclk !== 1'b1) begin
      errors++;
      $display("FAIL first_rise bclk=%b expected 1", bclk);
    end
    repeat (10) @(negedge clk);
    en_clk = 1'b0;
    wait_idle();
    checks++;
    if (busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL single_drain busy=%b pending=%0d expected 0 0", busy, q.size());
    end
  endtask

  task automatic test_back_to_back();
    int ur0 = ur_cnt;
    int n = 0;
    starts.delete();
    en_clk = 1'b1;
    send(16'h8001);
    send(16'h7FFE);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall s_ready=%b expected 0", s_ready);
    end
    while (s_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    en_clk = 1'b0;
    wait_idle();
    checks++;
    if (busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain busy=%b pending=%0d expected 0 0", busy, q.size());
    end
    checks++;
    if (starts.size() != 2) begin
      errors++;
      $display("FAIL b2b_frames got %0d expected 2", starts.size());
    end else if (starts[1] - starts[0] != 128) begin
      errors++;
      $display("FAIL b2b_spacing got %0d expected 128", starts[1] - starts[0]);
    end
    checks++;
    if (ur_cnt != ur0) begin
      errors++;
      $display("FAIL b2b_underrun got %0d expected 0", ur_cnt - ur0);
    end
  endtask

  task automatic test_underrun();
    int ur0 = ur_cnt;
    int n = 0;
    starts.delete();
    en_clk = 1'b1;
    send(16'h1234);
    push_frame(16'h0000);
    while (underrun !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (underrun !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ur_pulse underrun=%b s_ready=%b busy=%b expected 1 1 1",
               underrun, s_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_width underrun=%b expected 0", underrun);
    end
    en_clk = 1'b0;
    wait_idle();
    checks++;
    if (busy !== 1'b0 || q.size() != 0 || ur_cnt - ur0 != 1) begin
      errors++;
      $display("FAIL ur_drain busy=%b pending=%0d pulses=%0d expected 0 0 1",
               busy, q.size(), ur_cnt - ur0);
    end
    checks++;
    if (starts.size() != 2 || starts[1] - starts[0] != 128) begin
      errors++;
      $display("FAIL ur_spacing frames=%0d expected 2 frames 128 apart",
               starts.size());
    end
  endtask

  task automatic test_drop_en();
    int   base;
    int   n = 0;
    logic pb = 1'b0;
    en_clk = 1'b1;
    send(16'hF00F);
    base = rises;
    while (rises - base < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    en_clk = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      pb = bclk;
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || pb !== 1'b1 || bclk !== 1'b0) begin
      errors++;
      $display("FAIL drop_edge busy=%b prev_bclk=%b bclk=%b expected 0 1 0",
               busy, pb, bclk);
    end
    checks++;
    if (rises - base != 32 || q.size() != 0) begin
      errors++;
      $display("FAIL drop_bits got %0d pending=%0d expected 32 0",
               rises - base, q.size());
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bclk !== 1'b0 || rises - base != 32) begin
      errors++;
      $display("FAIL drop_quiet bclk=%b rises=%0d expected 0 32",
               bclk, rises - base);
    end
  endtask

  task automatic test_async_reset();
    int base;
    int n = 0;
    int bad = 0;
    en_clk = 1'b1;
    send(16'hFFFF);
    send(16'h5555);
    base = rises;
    while (rises - base < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bclk, ws, sdata, s_ready, underrun, busy} !== 6'b000100) begin
      errors++;
      $display("FAIL async_reset got %b expected 000100",
               {bclk, ws, sdata, s_ready, underrun, busy});
    end
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    base = rises;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rises != base || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset busy_cycles=%0d rises=%0d s_ready=%b expected 0 0 1",
               bad, rises - base, s_ready);
    end
    en_clk = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_drop_en();
    test_async_reset();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time=%0t expected completion", $time);
    $fatal(1);
  end

endmodule
